owr_master: RTL and testbench

Byte-level 1-Wire bus master that sequences the single open-drain 1-Wire pin for the temperature-sensor logic. It accepts RESET, WRITE-byte and READ-byte commands over a valid/ready handshake and generates the 1-Wire reset/presence and time-slot waveforms. It returns presence and sampled data on a one-cycle response strobe. It sits between the sensor protocol logic and the pin buffer: owr_out drives the buffer output enable (1 = pull line low), and owr_in is the raw pin input.

---
 rtl/owr_master.sv | 176 +++++++++++++++++
 tb/tb_owr_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/owr_master.sv
// Byte-level 1-Wire bus master: RESET/presence, WRITE-byte and READ-byte
// sequencing of one open-drain pin, with valid/ready command and response strobe.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   cmd_valid/ready command handshake; cmd_op 00=RESET 01=WRITE 10=READ 11=illegal
//   cmd_data        byte to write, LSB first
//   rsp_valid       one-cycle completion strobe
//   rsp_data        bits sampled in the 8 slots, LSB first
//   rsp_presence    RESET result (1 = device answered)
//   rsp_err         illegal op
//   owr_out         1 = pull the line low, 0 = release
//   owr_in          raw line level (asynchronous)
module owr_master #(
    parameter int CLK_PER_US = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_presence,
    output logic       rsp_err,
    output logic       owr_out,
    input  logic       owr_in
);

    localparam int RST_LEN  = 480 * CLK_PER_US;
    localparam int SLOT_LEN = 70 * CLK_PER_US;
    localparam int PRES_PT  = 70 * CLK_PER_US - 1;
    localparam int SAMP_PT  = 15 * CLK_PER_US - 1;
    localparam int W0_LEN   = 60 * CLK_PER_US;
    localparam int W1_LEN   = 6 * CLK_PER_US;
    localparam int CW       = $clog2(RST_LEN);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RST_LOW = 3'd1;
    localparam logic [2:0] S_RST_REL = 3'd2;
    localparam logic [2:0] S_SLOT    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    idx;
    logic [2:0]    idx_n;
    logic [1:0]    op;
    logic [1:0]    op_n;
    logic [7:0]    data;
    logic [7:0]    data_n;
    logic [7:0]    shift;
    logic          sync1;
    logic          owr_s;
    logic          presence_reg;
    logic          accept;
    logic          long_low;
    logic          owr_n;

    assign cmd_ready = !rst && (state == S_IDLE || state == S_DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = (state == S_DONE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        case (state)
            S_IDLE, S_DONE: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                idx_n   = '0;
                if (accept) begin
                    case (cmd_op)
                        2'b00:   state_n = S_RST_LOW;
                        2'b01:   state_n = S_SLOT;
                        2'b10:   state_n = S_SLOT;
                        default: state_n = S_DONE;
                    endcase
                end
            end
            S_RST_LOW: begin
                if (cnt == CW'(RST_LEN - 1)) begin
                    state_n = S_RST_REL;
                    cnt_n   = '0;
                end
            end
            S_RST_REL: begin
                if (cnt == CW'(RST_LEN - 1)) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                end
            end
            S_SLOT: begin
                if (cnt == CW'(SLOT_LEN - 1)) begin
                    cnt_n = '0;
                    if (idx == 3'd7) state_n = S_DONE;
                    else             idx_n   = idx + 3'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

    // owr_out is registered, so its next value is derived from the
    // next-cycle state, counter and (possibly just latched) command.
    always_comb begin
        op_n     = accept ? cmd_op : op;
        data_n   = accept ? cmd_data : data;
        long_low = (op_n == 2'b01) && !data_n[idx_n];
        owr_n    = 1'b0;
        if (state_n == S_RST_LOW) begin
            owr_n = 1'b1;
        end else if (state_n == S_SLOT) begin
            owr_n = long_low ? (cnt_n < CW'(W0_LEN))
                             : (cnt_n < CW'(W1_LEN));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            idx          <= '0;
            op           <= '0;
            data         <= '0;
            shift        <= '0;
            sync1        <= 1'b1;
            owr_s        <= 1'b1;
            presence_reg <= 1'b0;
            owr_out      <= 1'b0;
            rsp_data     <= '0;
            rsp_presence <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            sync1   <= owr_in;
            owr_s   <= sync1;
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            owr_out <= owr_n;
            if (accept) begin
                op    <= cmd_op;
                data  <= cmd_data;
                shift <= '0;
            end
            if (state == S_SLOT && cnt == CW'(SAMP_PT))
                shift[idx] <= owr_s;
            if (state == S_RST_REL && cnt == CW'(PRES_PT))
                presence_reg <= ~owr_s;
            if (state == S_RST_REL && state_n == S_DONE) begin
                rsp_data     <= '0;
                rsp_presence <= presence_reg;
                rsp_err      <= 1'b0;
            end
            if (state == S_SLOT && state_n == S_DONE) begin
                rsp_data     <= shift;
                rsp_presence <= 1'b0;
                rsp_err      <= 1'b0;
            end
            if (accept && cmd_op == 2'b11) begin
                rsp_data     <= '0;
                rsp_presence <= 1'b0;
                rsp_err      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_owr_master.sv
// Directed bench for owr_master at CLK_PER_US=4 with a simple
// 1-Wire device model on the line.
module tb_owr_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_presence;
    logic       rsp_err;
    logic       owr_out;
    logic       owr_in;

    owr_master #(.CLK_PER_US(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_presence (rsp_presence),
        .rsp_err      (rsp_err),
        .owr_out      (owr_out),
        .owr_in       (owr_in)
    );

    always #5 clk = ~clk;

    // Device model. mode 1: presence pulse 100..300 cycles after the
    // master releases. mode 2: hold low 120 cycles (30 us) after the
    // slot start in slots flagged by read_mask.
    int         mode = 0;
    logic [7:0] read_mask = 8'h00;
    logic       prev_out = 1'b0;
    int         fall_cnt = 100000;
    int         rise_cnt = 100000;
    int         nrise = 0;
    int         nrise_base = 0;
    int         slot;
    logic       dev_pull;

    always @(posedge clk) begin
        prev_out <= owr_out;
        if (prev_out && !owr_out) fall_cnt <= 0;
        else if (fall_cnt < 100000) fall_cnt <= fall_cnt + 1;
        if (!prev_out && owr_out) begin
            rise_cnt <= 0;
            nrise    <= nrise + 1;
        end else if (rise_cnt < 100000) begin
            rise_cnt <= rise_cnt + 1;
        end
    end

    always_comb begin
        slot     = nrise - nrise_base - 1;
        dev_pull = 1'b0;
        if (mode == 1 && fall_cnt >= 100 && fall_cnt < 300)
            dev_pull = 1'b1;
        if (mode == 2 && rise_cnt < 120 && slot >= 0 && slot < 8)
            dev_pull = read_mask[slot[2:0]];
    end

    assign owr_in = !(owr_out || dev_pull);

    int npass = 0;
    int nchk  = 0;
    int nfail = 0;

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    int         widths[16];
    int         rises[16];
    int         nw;
    int         nr;
    int         hi_total;
    int         lat;
    logic [7:0] r_data;
    logic       r_pres;
    logic       r_err;

    // Monitor owr_out high runs and rsp_valid, counting cycle n=1 as the
    // cycle right after the acceptance edge.
    task automatic monitor(input int maxc);
        int   run;
        logic last;
        run = 0; nw = 0; nr = 0; hi_total = 0; lat = -1; last = 1'b0;
        for (int n = 1; n <= maxc; n++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (owr_out) begin
                if (!last && nr < 16) begin
                    rises[nr] = n;
                    nr++;
                end
                run++;
            end else if (run > 0) begin
                if (nw < 16) widths[nw] = run;
                nw++;
                hi_total += run;
                run = 0;
            end
            last = owr_out;
            if (rsp_valid) begin
                lat    = n;
                r_data = rsp_data;
                r_pres = rsp_presence;
                r_err  = rsp_err;
                break;
            end
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] d,
                           input int maxc);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        check("ready_at_issue", cmd_ready, 1);
        monitor(maxc);
    endtask

    int exp_w[8] = '{24, 240, 24, 240, 240, 24, 240, 24};
    int stray;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_owr_out", owr_out, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_pres", rsp_presence, 0);
        check("rst_rsp_err", rsp_err, 0);
        cmd_valid = 1'b1;
        @(negedge clk);
        check("valid_in_rst_ready", cmd_ready, 0);
        rst = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("ready_after_rst", cmd_ready, 1);

        // RESET with a device answering
        mode = 1;
        run_cmd(2'b00, 8'h00, 5000);
        check("reset_low_total", hi_total, 1920);
        check("reset_low_runs", nw, 1);
        check("reset_first_low", rises[0], 1);
        check("reset_latency", lat, 3841);
        check("reset_presence", r_pres, 1);
        check("reset_data", r_data, 0);
        check("reset_err", r_err, 0);

        // RESET with no device
        mode = 0;
        run_cmd(2'b00, 8'h00, 5000);
        check("nodev_latency", lat, 3841);
        check("nodev_presence", r_pres, 0);

        // WRITE 0xA5 on an idle-high line
        run_cmd(2'b01, 8'hA5, 3000);
        check("wr_low_runs", nw, 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("wr_low_w%0d", i), widths[i], exp_w[i]);
        for (int i = 1; i < 8; i++)
            check($sformatf("wr_period%0d", i), rises[i] - rises[i-1], 280);
        check("wr_latency", lat, 2241);
        check("wr_data", r_data, 8'hA5);
        check("wr_pres", r_pres, 0);

        // READ with device zeroing bits 1, 3, 4
        mode = 2;
        read_mask = 8'b0001_1010;
        nrise_base = nrise;
        run_cmd(2'b10, 8'h00, 3000);
        check("rd_low_runs", nw, 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("rd_low_w%0d", i), widths[i], 24);
        check("rd_latency", lat, 2241);
        check("rd_data", r_data, 8'hE5);
        mode = 0;

        // illegal op
        run_cmd(2'b11, 8'h5A, 20);
        check("ill_latency", lat, 1);
        check("ill_err", r_err, 1);
        check("ill_data", r_data, 0);
        check("ill_owr_low", hi_total, 0);
        @(negedge clk);
        check("ill_owr_after", owr_out, 0);

        // back-to-back: RESET then READ with cmd_valid held
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        lat = -1;
        for (int n = 1; n <= 5000; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
        check("b2b_reset_latency", lat, 3841);
        check("b2b_done_ready", cmd_ready, 1);
        check("b2b_done_owr", owr_out, 0);
        cmd_op = 2'b10;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_read_first_low", owr_out, 1);
        lat = -1;
        for (int n = 2; n <= 3000; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat    = n;
                r_data = rsp_data;
                break;
            end
        end
        check("b2b_read_latency", lat, 2241);
        check("b2b_read_data", r_data, 8'hFF);

        // rst in the middle of WRITE 0x00
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 8'h00;
        for (int n = 1; n <= 500; n++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        check("mid_owr_before", owr_out, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_owr_after", owr_out, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_ready_in_rst", cmd_ready, 0);
        check("mid_rsp_data_clr", rsp_data, 0);
        check("mid_rsp_err_clr", rsp_err, 0);
        rst = 1'b0;
        #1;
        check("mid_ready_after", cmd_ready, 1);
        stray = 0;
        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            if (rsp_valid || owr_out) stray++;
        end
        check("mid_no_activity", stray, 0);

        run_cmd(2'b10, 8'h00, 3000);
        check("post_rd_latency", lat, 2241);
        check("post_rd_data", r_data, 8'hFF);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
